clock_disp_scan: RTL and testbench



---
 rtl/clock_disp_scan_pkg.sv | 45 ++++
 rtl/clock_disp_scan_if.sv | 28 ++
 rtl/clock_disp_scan_bin2bcd.sv | 22 ++
 rtl/clock_disp_scan.sv | 118 +++++++++++
 tb/tb_clock_disp_scan.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/clock_disp_scan_pkg.sv
// Shared constants for the time-display scanner.
// Holds the seven-segment codes ({g,f,e,d,c,b,a}, 1 = lit),
// the digit-position constants (digit 0 is rightmost),
// and the BCD-to-segment decoder used by the output stage.
package clock_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  // Codes above 9 never reach here from a valid field; show a dash
  // so any stray value is visibly wrong rather than blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/clock_disp_scan_if.sv
// Bus between the clock counter / board pins and the display scanner.
//   sec_in, min_in, hr_in : binary time fields (legal 0..59, 0..59, 0..23)
//   blank                 : 1 = all digit enables off, scanning continues
//   seg                   : segments {g,f,e,d,c,b,a} at the pins
//   dp                    : decimal point, used as blinking colon
//   an                    : one-hot digit enable at the pins
//   digit_idx             : digit currently scanned, 0..5
// master = time source / board side, slave = scanner.
interface clock_disp_scan_if;
  logic [5:0] sec_in;
  logic [5:0] min_in;
  logic [4:0] hr_in;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic [2:0] digit_idx;

  modport master (
    output sec_in, min_in, hr_in, blank,
    input  seg, dp, an, digit_idx
  );

  modport slave (
    input  sec_in, min_in, hr_in, blank,
    output seg, dp, an, digit_idx
  );
endinterface

// File: rtl/clock_disp_scan_bin2bcd.sv
// Two-digit binary-to-BCD converter for one time field.
//   value    : 6-bit binary field
//   tens     : value / 10
//   units    : value % 10
//   in_range : 1 when value <= LIMIT (59 for sec/min, 23 for hours)
// Division is by a constant, so it reduces to a small lookup.
module bin2bcd_2dig #(
  parameter int LIMIT = 59
) (
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       in_range
);

  always_comb begin
    tens     = 4'(value / 6'd10);
    units    = 4'(value % 6'd10);
    in_range = (value <= 6'(LIMIT));
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed seven-segment time display scanner.
// Snapshots sec/min/hr once per frame, converts each field to BCD and
// lights one digit at a time for SCAN_DIV clocks.
//   clk, rst   : system clock, synchronous active-high reset
//   bus.slave  : time inputs and blank in; seg, dp, an, digit_idx out
// Parameters:
//   SCAN_DIV   : clocks each digit stays lit (>= 2)
//   ACTIVE_LOW : 1 inverts seg, dp and an at the pins
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  clock_disp_scan_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [2:0]    digit_idx, idx_nxt;
  logic [5:0]    snap_sec, snap_sec_nxt;
  logic [5:0]    snap_min, snap_min_nxt;
  logic [4:0]    snap_hr, snap_hr_nxt;
  logic          first_cycle;
  logic          advance, load;

  logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic          sec_ok, min_ok, hr_ok;

  logic [6:0]    seg_nxt, seg_r;
  logic          dp_nxt, dp_r;
  logic [5:0]    an_nxt, an_r;

  // Next-state of prescaler, digit counter and snapshot. The snapshot
  // loads on the first cycle out of reset and on every 5->0 wrap, so a
  // whole frame always shows one coherent time.
  always_comb begin
    advance  = (pcnt == PCNT_LAST);
    pcnt_nxt = advance ? '0 : pcnt + 1'b1;
    if (!advance)
      idx_nxt = digit_idx;
    else if (digit_idx == DIG_HR_T)
      idx_nxt = DIG_SEC_U;
    else
      idx_nxt = digit_idx + 3'd1;
    load         = first_cycle | (advance & (digit_idx == DIG_HR_T));
    snap_sec_nxt = load ? bus.sec_in : snap_sec;
    snap_min_nxt = load ? bus.min_in : snap_min;
    snap_hr_nxt  = load ? bus.hr_in  : snap_hr;
  end

  // Converters look at the next-state snapshot so that the digit shown
  // right after a wrap already reflects the freshly captured time.
  bin2bcd_2dig #(.LIMIT(59)) u_sec (
    .value(snap_sec_nxt), .tens(sec_t), .units(sec_u), .in_range(sec_ok)
  );
  bin2bcd_2dig #(.LIMIT(59)) u_min (
    .value(snap_min_nxt), .tens(min_t), .units(min_u), .in_range(min_ok)
  );
  bin2bcd_2dig #(.LIMIT(23)) u_hr (
    .value({1'b0, snap_hr_nxt}), .tens(hr_t), .units(hr_u), .in_range(hr_ok)
  );

  // Decode of the digit about to be lit. An out-of-range field dashes
  // both of its digits. The colon shows on min-units and hr-units
  // during even seconds.
  always_comb begin
    seg_nxt = SEG_OFF;
    case (idx_nxt)
      DIG_SEC_U: seg_nxt = sec_ok ? bcd_to_seg(sec_u) : SEG_DASH;
      DIG_SEC_T: seg_nxt = sec_ok ? bcd_to_seg(sec_t) : SEG_DASH;
      DIG_MIN_U: seg_nxt = min_ok ? bcd_to_seg(min_u) : SEG_DASH;
      DIG_MIN_T: seg_nxt = min_ok ? bcd_to_seg(min_t) : SEG_DASH;
      DIG_HR_U:  seg_nxt = hr_ok  ? bcd_to_seg(hr_u)  : SEG_DASH;
      DIG_HR_T:  seg_nxt = hr_ok  ? bcd_to_seg(hr_t)  : SEG_DASH;
      default:   seg_nxt = SEG_OFF;
    endcase
    dp_nxt = ((idx_nxt == DIG_MIN_U) || (idx_nxt == DIG_HR_U)) && !snap_sec_nxt[0];
    an_nxt = bus.blank ? 6'b000000 : (6'b000001 << idx_nxt);
  end

  // State and output registers. Reset leaves everything dark and arms
  // the first-cycle snapshot load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      digit_idx   <= DIG_SEC_U;
      snap_sec    <= '0;
      snap_min    <= '0;
      snap_hr     <= '0;
      first_cycle <= 1'b1;
      seg_r       <= SEG_OFF;
      dp_r        <= 1'b0;
      an_r        <= '0;
    end else begin
      pcnt        <= pcnt_nxt;
      digit_idx   <= idx_nxt;
      snap_sec    <= snap_sec_nxt;
      snap_min    <= snap_min_nxt;
      snap_hr     <= snap_hr_nxt;
      first_cycle <= 1'b0;
      seg_r       <= seg_nxt;
      dp_r        <= dp_nxt;
      an_r        <= an_nxt;
    end
  end

  // Pin polarity is applied last so reset values invert as well.
  assign bus.seg       = ACTIVE_LOW ? ~seg_r : seg_r;
  assign bus.dp        = ACTIVE_LOW ? ~dp_r  : dp_r;
  assign bus.an        = ACTIVE_LOW ? ~an_r  : an_r;
  assign bus.digit_idx = digit_idx;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Self-checking bench for clock_disp_scan with SCAN_DIV = 4, ACTIVE_LOW = 0.
// A frame-level model derives what each digit must show from the number
// of clocks since reset; directed checks pin specific display values.
module tb_clock_disp_scan;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  clock_disp_scan_if dif ();

  clock_disp_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state: clocks since reset release and the time captured for
  // the current frame.
  int         k = 0;
  int         m_sec = 0, m_min = 0, m_hr = 0;
  logic [6:0] e_seg = '0;
  logic       e_dp = 1'b0;
  logic [5:0] e_an = '0;
  logic [2:0] e_idx = '0;
  bit         model_ok = 1'b0;

  function automatic logic [6:0] model_seg(int idx, int s, int m, int h);
    int v, lim, d;
    v   = (idx < 2) ? s : (idx < 4) ? m : h;
    lim = (idx < 4) ? 59 : 23;
    if (v > lim) return 7'h40;
    d = (idx % 2 == 1) ? v / 10 : v % 10;
    return seg_tab[d];
  endfunction

  // Each digit lasts SD clocks and a frame is 6*SD clocks; the frame's
  // time is taken at the first clock out of reset and at every frame
  // boundary.
  always @(posedge clk) begin
    int idx;
    if (rst) begin
      k = 0; m_sec = 0; m_min = 0; m_hr = 0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_idx = '0;
    end else begin
      k++;
      if (k == 1 || (k % (6 * SD)) == 0) begin
        m_sec = int'(dif.sec_in);
        m_min = int'(dif.min_in);
        m_hr  = int'(dif.hr_in);
      end
      idx   = (k / SD) % 6;
      e_idx = 3'(idx);
      e_seg = model_seg(idx, m_sec, m_min, m_hr);
      e_dp  = (idx == 2 || idx == 4) && (m_sec % 2 == 0);
      e_an  = dif.blank ? 6'b0 : 6'(1 << idx);
    end
    model_ok = 1'b1;
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      cmp("model.seg", int'(dif.seg), int'(e_seg));
      cmp("model.dp", int'(dif.dp), int'(e_dp));
      cmp("model.an", int'(dif.an), int'(e_an));
      cmp("model.idx", int'(dif.digit_idx), int'(e_idx));
    end
  end

  task automatic applyStimulus(input int s, input int m, input int h, input bit b);
    dif.sec_in = 6'(s);
    dif.min_in = 6'(m);
    dif.hr_in  = 5'(h);
    dif.blank  = b;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] s, input logic d,
                             input logic [5:0] a, input logic [2:0] i);
    cmp({name, ".seg"}, int'(dif.seg), int'(s));
    cmp({name, ".dp"}, int'(dif.dp), int'(d));
    cmp({name, ".an"}, int'(dif.an), int'(a));
    cmp({name, ".idx"}, int'(dif.digit_idx), int'(i));
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    applyStimulus(58, 59, 23, 1'b0);
    rst = 1'b1;
    waitEdges(3);
    checkOutput("reset", 7'h00, 1'b0, 6'b000000, 3'd0);
    rst = 1'b0;

    // Full frame at 23:59:58 (edge counts are clocks since release)
    waitEdges(1);  checkOutput("frame.d0", 7'h7F, 1'b0, 6'b000001, 3'd0);
    waitEdges(3);  checkOutput("frame.d1", 7'h6D, 1'b0, 6'b000010, 3'd1);
    waitEdges(4);  checkOutput("frame.d2", 7'h6F, 1'b1, 6'b000100, 3'd2);
    waitEdges(4);  checkOutput("frame.d3", 7'h6D, 1'b0, 6'b001000, 3'd3);
    waitEdges(4);  checkOutput("frame.d4", 7'h4F, 1'b1, 6'b010000, 3'd4);
    waitEdges(4);  checkOutput("frame.d5", 7'h5B, 1'b0, 6'b100000, 3'd5);

    // Tear-free: 12:34:58 captured at clock 24, sec changes during idx 3
    applyStimulus(58, 34, 12, 1'b0);
    waitEdges(4);  checkOutput("tear.d0", 7'h7F, 1'b0, 6'b000001, 3'd0);
    waitEdges(4);  checkOutput("tear.d1", 7'h6D, 1'b0, 6'b000010, 3'd1);
    waitEdges(8);  checkOutput("tear.d3", 7'h4F, 1'b0, 6'b001000, 3'd3);
    applyStimulus(59, 34, 12, 1'b0);
    waitEdges(4);  checkOutput("tear.d4", 7'h5B, 1'b1, 6'b010000, 3'd4);
    waitEdges(8);  checkOutput("tear.next_d0", 7'h6F, 1'b0, 6'b000001, 3'd0);
    waitEdges(8);  checkOutput("tear.next_d2", 7'h66, 1'b0, 6'b000100, 3'd2);

    // Out of range minutes and hours, captured at clock 72
    applyStimulus(7, 60, 24, 1'b0);
    waitEdges(16); checkOutput("oor.d0", 7'h07, 1'b0, 6'b000001, 3'd0);
    waitEdges(4);  checkOutput("oor.d1", 7'h3F, 1'b0, 6'b000010, 3'd1);
    waitEdges(4);  checkOutput("oor.d2", 7'h40, 1'b0, 6'b000100, 3'd2);
    waitEdges(12); checkOutput("oor.d5", 7'h40, 1'b0, 6'b100000, 3'd5);

    // blank for 5 clocks starting mid-digit (clock 93)
    waitEdges(1);
    applyStimulus(7, 60, 24, 1'b1);
    waitEdges(1);  checkOutput("blank.on", 7'h40, 1'b0, 6'b000000, 3'd5);
    waitEdges(4);  checkOutput("blank.wrap", 7'h07, 1'b0, 6'b000000, 3'd0);
    applyStimulus(7, 60, 24, 1'b0);
    waitEdges(1);  checkOutput("blank.off", 7'h07, 1'b0, 6'b000001, 3'd0);

    // Reset mid-frame at idx 4, pcnt 2 (clock 138), new time 10:20:31
    waitEdges(39);
    cmp("prereset.idx", int'(dif.digit_idx), 4);
    applyStimulus(31, 20, 10, 1'b0);
    rst = 1'b1;
    waitEdges(1);  checkOutput("midrst", 7'h00, 1'b0, 6'b000000, 3'd0);
    rst = 1'b0;
    waitEdges(1);  checkOutput("post.d0", 7'h06, 1'b0, 6'b000001, 3'd0);
    waitEdges(7);  checkOutput("post.d2", 7'h3F, 1'b0, 6'b000100, 3'd2);
    waitEdges(8);  checkOutput("post.d4", 7'h3F, 1'b0, 6'b010000, 3'd4);
    waitEdges(4);  checkOutput("post.d5", 7'h06, 1'b0, 6'b100000, 3'd5);

    waitEdges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
